fifo_wr_arbiter: RTL

- Round-robin write-port arbiter that shares one synchronous byte FIFO among NREQ producers.
- Each producer presents a valid/ready stream. The arbiter grants one producer at a time for a bounded burst and steers its data onto the FIFO write port.
- Sits directly in front of the FIFO write interface (wr_en, buf_in, buf_full); the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write-port arbiter sharing one byte FIFO among
// NREQ valid/ready producers. Each grant lasts for at most MAX_BURST beats.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   req_valid       per-requester data valid
//   req_data        packed requester data, requester i at [i*DW +: DW]
//   req_ready       per-requester accept (combinational)
//   fifo_full       FIFO full flag
//   fifo_wr_en      FIFO write enable (combinational)
//   fifo_wr_data    FIFO write data (combinational)
//   grant_valid     a burst grant is active
//   grant_id        index of the granted requester
//   stall_cnt       cycles the granted requester was blocked by a full FIFO
//
// Optional feature: define FIFO_ARB_STALL_CNT_EN to build the saturating
// stall counter; otherwise stall_cnt is tied to zero.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDW       = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_wr_data,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant_id,
  output logic [15:0]        stall_cnt
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state;
  logic [IDW-1:0] last_grant;
  logic [7:0]     beat_cnt;

  logic [IDW-1:0]     winner_c;
  logic [2*NREQ-1:0]  rot_c;
  logic               g_valid_c;
  logic [DW-1:0]      g_data_c;
  logic               xfer_c;
  logic               last_beat_c;

  // Round-robin pick: rotate the doubled request vector so bit 0 is the
  // requester after last_grant, then take the lowest set bit.
  always_comb begin
    int off;
    int sum;
    off      = 0;
    sum      = 0;
    rot_c    = {req_valid, req_valid} >> (int'(last_grant) + 1);
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot_c[i]) off = i;
    end
    sum = int'(last_grant) + 1 + off;
    if (sum >= int'(NREQ)) sum = sum - int'(NREQ);
    winner_c = IDW'(sum);
  end

  // Mux out the granted requester's valid and data.
  always_comb begin
    g_valid_c = 1'b0;
    g_data_c  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (IDW'(i) == grant_id) begin
        g_valid_c = req_valid[i];
        g_data_c  = req_data[i*DW +: DW];
      end
    end
  end

  assign xfer_c      = (state == BURST) && g_valid_c && !fifo_full;
  assign last_beat_c = (beat_cnt == 8'(MAX_BURST - 1));

  // Handshake and FIFO write port; ready follows fifo_full combinationally so
  // a write can never land on a full FIFO.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    if (state == BURST) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (IDW'(i) == grant_id) req_ready[i] = !fifo_full;
      end
      fifo_wr_en   = xfer_c;
      fifo_wr_data = g_data_c;
    end
  end

  // Arbitration / burst FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_grant  <= IDW'(NREQ - 1);
      beat_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id    <= winner_c;
            last_grant  <= winner_c;
            beat_cnt    <= '0;
            grant_valid <= 1'b1;
            state       <= BURST;
          end
        end
        BURST: begin
          if (!g_valid_c) begin
            // Requester went idle: surrender the grant without a transfer.
            grant_valid <= 1'b0;
            state       <= IDLE;
          end else if (xfer_c) begin
            if (last_beat_c) begin
              grant_valid <= 1'b0;
              state       <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  // Saturating count of cycles the granted requester was blocked by full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if ((state == BURST) && g_valid_c && fifo_full &&
                 (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
